// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at a time: req/ready accept, rvalid/rdata return.
interface if_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch with IF/ID pipeline register, one-entry skid buffer for
// responses that land during a stall, and redirect/flush from branch resolution.
module if_stage #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    INST_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter int                    OPCODE_WIDTH   = 7,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST       = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  if_stage_if.master                imem,
  output logic                      if_id_valid,
  output logic [ADDR_WIDTH-1:0]     if_id_pc,
  output logic [INST_WIDTH-1:0]     if_id_inst,
  output logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
  output logic [REG_ADDR_WIDTH-1:0] if_id_rs2,
  output logic [REG_ADDR_WIDTH-1:0] if_id_rd,
  output logic [OPCODE_WIDTH-1:0]   if_id_opcode
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_WIDTH-1:0]   skid_inst_q, skid_inst_d;
  logic                    ifid_valid_q, ifid_valid_d;
  logic [ADDR_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [INST_WIDTH-1:0]   ifid_inst_q, ifid_inst_d;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   pc_plus4;

  assign accept   = (state_q == S_REQ) && imem.imem_ready;
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;

    // ID consumes IF/ID every unstalled cycle; a bubble shows the NOP.
    if (!stall_in) begin
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
    end

    unique case (state_q)
      S_REQ: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          pc_d = pc_plus4;
          if (!stall_in) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = imem.imem_rdata;
            state_d      = S_REQ;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_inst_d  = imem.imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_in && skid_valid_q) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = skid_pc_q;
          ifid_inst_d  = skid_inst_q;
          skid_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides stall and every FSM action above.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      ifid_valid_d = 1'b0;
      ifid_inst_d  = NOP_INST;
      skid_valid_d = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = accept ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;

  assign if_id_valid  = ifid_valid_q;
  assign if_id_pc     = ifid_pc_q;
  assign if_id_inst   = ifid_inst_q;
  assign if_id_rs1    = ifid_inst_q[19:15];
  assign if_id_rs2    = ifid_inst_q[24:20];
  assign if_id_rd     = ifid_inst_q[11:7];
  assign if_id_opcode = ifid_inst_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one vector per clock cycle, inputs applied
// before the edge and registered outputs compared 1 time unit after it.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic [4:0]  if_id_rs1, if_id_rs2, if_id_rd;
  logic [6:0]  if_id_opcode;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .if_id_rd       (if_id_rd),
    .if_id_opcode   (if_id_opcode)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc,
                              logic rdy, logic rv, logic [31:0] rdata,
                              logic req, logic [31:0] addr, logic v,
                              logic [31:0] pc, logic [31:0] inst);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rpc;
    t.rdy = rdy; t.rv = rv; t.rdata = rdata;
    t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.inst = inst;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t t);
    logic [31:0] ei;
    logic [23:0] ef, af;
    rst                = t.rst;
    stall_in           = t.stall;
    redirect_valid     = t.redir;
    redirect_pc        = t.rpc;
    bus.imem_ready     = t.rdy;
    bus.imem_rvalid    = t.rv;
    bus.imem_rdata     = t.rdata;
    @(posedge clk);
    #1;
    cyc++;
    ei = t.inst;
    ef = {ei[19:15], ei[24:20], ei[11:7], ei[6:0]};
    af = {if_id_rs1, if_id_rs2, if_id_rd, if_id_opcode};
    chk({tag, " imem_req"},    {31'd0, bus.imem_req}, {31'd0, t.req});
    chk({tag, " imem_addr"},   bus.imem_addr,         t.addr);
    chk({tag, " if_id_valid"}, {31'd0, if_id_valid},  {31'd0, t.v});
    chk({tag, " if_id_pc"},    if_id_pc,              t.pc);
    chk({tag, " if_id_inst"},  if_id_inst,            t.inst);
    chk({tag, " fields"},      {8'd0, af},            {8'd0, ef});
    $display("cycle %0d %s: req=%b addr=%h valid=%b pc=%h inst=%h",
             cyc, tag, bus.imem_req, bus.imem_addr, if_id_valid, if_id_pc, if_id_inst);
  endtask

  vec_t tbl [20];

  initial begin
    //           rst s  rd rpc           rdy rv rdata          req addr          v  pc            inst
    tbl[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        NOP);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_00A5, 1, 32'h4,        1, 32'h0,        32'h0000_00A5);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        0, 32'h0,        NOP);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_00A1, 1, 32'h8,        1, 32'h4,        32'h0000_00A1);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        0, 32'h4,        NOP);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_00AD, 1, 32'hC,        1, 32'h8,        32'h0000_00AD);
    // redirect while waiting: late response dropped, refetch at 0x100
    tbl[6]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        0, 32'h8,        NOP);
    tbl[7]  = mk(0, 0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h100,      0, 32'h8,        NOP);
    tbl[8]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_00A9, 1, 32'h100,      0, 32'h8,        NOP);
    tbl[9]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100,      0, 32'h8,        NOP);
    tbl[10] = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_01A5, 1, 32'h104,      1, 32'h100,      32'h0000_01A5);
    // redirect together with stall: flush wins
    tbl[11] = mk(0, 1, 1, 32'h200,      0, 0, 32'h0,        1, 32'h200,      0, 32'h100,      NOP);
    tbl[12] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h200,      0, 32'h100,      NOP);
    tbl[13] = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_02A5, 1, 32'h204,      1, 32'h200,      32'h0000_02A5);
    // redirect in the same cycle the old pc is accepted, to the top word
    tbl[14] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h200,      NOP);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_02A1, 1, 32'hFFFF_FFFC, 0, 32'h200,      NOP);
    tbl[16] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h200,      NOP);
    tbl[17] = mk(0, 0, 0, 32'h0,        0, 1, 32'hFFFF_FF59, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FF59);
    tbl[18] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, NOP);
    tbl[19] = mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_00A5, 1, 32'h4,        1, 32'h0,        32'h0000_00A5);

    step("reset0", mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, NOP));
    step("reset1", mk(1, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0, NOP));

    for (int i = 0; i < 20; i++) step($sformatf("vec%0d", i), tbl[i]);

    // stall for 5 cycles across a response; skid buffer releases it once
    step("stall1", mk(0, 1, 0, 0, 1, 0, 0,             0, 32'h4, 1, 32'h0, 32'h0000_00A5));
    step("stall2", mk(0, 1, 0, 0, 0, 1, 32'h0000_00A1, 0, 32'h8, 1, 32'h0, 32'h0000_00A5));
    step("stall3", mk(0, 1, 0, 0, 1, 0, 0,             0, 32'h8, 1, 32'h0, 32'h0000_00A5));
    step("stall4", mk(0, 1, 0, 0, 1, 0, 0,             0, 32'h8, 1, 32'h0, 32'h0000_00A5));
    step("stall5", mk(0, 1, 0, 0, 1, 0, 0,             0, 32'h8, 1, 32'h0, 32'h0000_00A5));
    step("release", mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h8, 1, 32'h4, 32'h0000_00A1));
    step("nodup",  mk(0, 0, 0, 0, 0, 0, 0,             1, 32'h8, 0, 32'h4, NOP));

    // reset while waiting; the orphan response lands in S_REQ and is ignored
    step("rw_acc", mk(0, 0, 0, 0, 1, 0, 0,             0, 32'h8, 0, 32'h4, NOP));
    step("rw_rst", mk(1, 0, 0, 0, 0, 0, 0,             1, 32'h0, 0, 32'h0, NOP));
    step("rw_ign", mk(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0, 0, 32'h0, NOP));
    step("rw_req", mk(0, 0, 0, 0, 1, 0, 0,             0, 32'h0, 0, 32'h0, NOP));
    step("rw_rsp", mk(0, 0, 0, 0, 0, 1, 32'h0000_00A5, 1, 32'h4, 1, 32'h0, 32'h0000_00A5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
